// File: rtl/hb_dec_tap_sequencer.sv
// Halfband decimator tap sequencer: writes samples into a circular RAM and, on every
// second sample, bursts symmetric tap-pair read addresses with MAC alignment flags.
module hb_dec_tap_sequencer #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned AWIDTH = 5,
   parameter int unsigned NPAIRS = 8,
   localparam int unsigned KW    = (NPAIRS > 1) ? $clog2(NPAIRS) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              strobe_in,
   input  logic [WIDTH-1:0]  data_in,
   output logic              write,
   output logic [AWIDTH-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic [AWIDTH-1:0] rd_addr1,
   output logic [AWIDTH-1:0] rd_addr2,
   output logic [AWIDTH-1:0] center_addr,
   output logic [KW-1:0]     coeff_idx,
   output logic              rd_valid,
   output logic              rd_first,
   output logic              rd_last,
   output logic              sum_valid,
   output logic              sum_first,
   output logic              sum_last,
   output logic              busy,
   output logic              overrun
);
   localparam int unsigned  SPAN   = 4 * NPAIRS - 2;
   localparam int unsigned  CENTER = 2 * NPAIRS - 1;
   localparam logic [KW-1:0] K_LAST = KW'(NPAIRS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q,       state_d;
   logic [AWIDTH-1:0]   ptr_q,         ptr_d;
   logic [AWIDTH-1:0]   newest_q,      newest_d;
   logic                phase_q,       phase_d;
   logic                write_q,       write_d;
   logic [AWIDTH-1:0]   wr_addr_q,     wr_addr_d;
   logic [WIDTH-1:0]    wr_data_q,     wr_data_d;
   logic [AWIDTH-1:0]   rd_addr1_q,    rd_addr1_d;
   logic [AWIDTH-1:0]   rd_addr2_q,    rd_addr2_d;
   logic [AWIDTH-1:0]   center_addr_q, center_addr_d;
   logic [KW-1:0]       coeff_idx_q,   coeff_idx_d;
   logic                rd_valid_q,    rd_valid_d;
   logic                rd_first_q,    rd_first_d;
   logic                rd_last_q,     rd_last_d;
   logic                sum_valid_q,   sum_valid_d;
   logic                sum_first_q,   sum_first_d;
   logic                sum_last_q,    sum_last_d;
   logic                busy_q,        busy_d;
   logic                overrun_q,     overrun_d;

   logic                accept;
   logic                trigger;
   logic [KW-1:0]       k_nxt;
   logic [AWIDTH-1:0]   two_k;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      newest_d      = newest_q;
      phase_d       = phase_q;
      write_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      rd_addr1_d    = rd_addr1_q;
      rd_addr2_d    = rd_addr2_q;
      center_addr_d = center_addr_q;
      coeff_idx_d   = coeff_idx_q;
      rd_valid_d    = rd_valid_q;
      rd_first_d    = rd_first_q;
      rd_last_d     = rd_last_q;
      busy_d        = busy_q;
      overrun_d     = overrun_q;
      // Sum flags are the read flags one clock later, independent of enable.
      sum_valid_d   = rd_valid_q;
      sum_first_d   = rd_first_q;
      sum_last_d    = rd_last_q;

      accept  = strobe_in & enable;
      trigger = accept & phase_q;
      k_nxt   = rd_valid_q ? coeff_idx_q + KW'(1) : '0;
      two_k   = AWIDTH'({k_nxt, 1'b0});

      if (accept) begin
         write_d   = 1'b1;
         wr_addr_d = ptr_q;
         wr_data_d = data_in;
         ptr_d     = ptr_q + AWIDTH'(1);
         phase_d   = ~phase_q;
      end

      if (!enable) begin
         state_d       = IDLE;
         phase_d       = 1'b0;
         busy_d        = 1'b0;
         rd_valid_d    = 1'b0;
         rd_first_d    = 1'b0;
         rd_last_d     = 1'b0;
         rd_addr1_d    = '0;
         rd_addr2_d    = '0;
         center_addr_d = '0;
         coeff_idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d  = RUN;
                  newest_d = ptr_q;
                  busy_d   = 1'b1;
               end
            end
            RUN: begin
               if (trigger) overrun_d = 1'b1;
               if (rd_valid_q && coeff_idx_q == K_LAST) begin
                  state_d       = IDLE;
                  busy_d        = 1'b0;
                  rd_valid_d    = 1'b0;
                  rd_first_d    = 1'b0;
                  rd_last_d     = 1'b0;
                  rd_addr1_d    = '0;
                  rd_addr2_d    = '0;
                  center_addr_d = '0;
                  coeff_idx_d   = '0;
               end else begin
                  rd_valid_d    = 1'b1;
                  coeff_idx_d   = k_nxt;
                  rd_first_d    = (k_nxt == '0);
                  rd_last_d     = (k_nxt == K_LAST);
                  rd_addr1_d    = newest_q - two_k;
                  rd_addr2_d    = newest_q - AWIDTH'(SPAN) + two_k;
                  center_addr_d = newest_q - AWIDTH'(CENTER);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         newest_q      <= '0;
         phase_q       <= 1'b0;
         write_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         rd_addr1_q    <= '0;
         rd_addr2_q    <= '0;
         center_addr_q <= '0;
         coeff_idx_q   <= '0;
         rd_valid_q    <= 1'b0;
         rd_first_q    <= 1'b0;
         rd_last_q     <= 1'b0;
         sum_valid_q   <= 1'b0;
         sum_first_q   <= 1'b0;
         sum_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         newest_q      <= newest_d;
         phase_q       <= phase_d;
         write_q       <= write_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         rd_addr1_q    <= rd_addr1_d;
         rd_addr2_q    <= rd_addr2_d;
         center_addr_q <= center_addr_d;
         coeff_idx_q   <= coeff_idx_d;
         rd_valid_q    <= rd_valid_d;
         rd_first_q    <= rd_first_d;
         rd_last_q     <= rd_last_d;
         sum_valid_q   <= sum_valid_d;
         sum_first_q   <= sum_first_d;
         sum_last_q    <= sum_last_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
      end
   end

   assign write       = write_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign rd_addr1    = rd_addr1_q;
   assign rd_addr2    = rd_addr2_q;
   assign center_addr = center_addr_q;
   assign coeff_idx   = coeff_idx_q;
   assign rd_valid    = rd_valid_q;
   assign rd_first    = rd_first_q;
   assign rd_last     = rd_last_q;
   assign sum_valid   = sum_valid_q;
   assign sum_first   = sum_first_q;
   assign sum_last    = sum_last_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_hb_dec_tap_sequencer.sv
// Bench for hb_dec_tap_sequencer: directed scenarios plus random traffic, checked
// against a burst-schedule reference model (edge-indexed, not cycle state machine).
module tb_hb_dec_tap_sequencer;
   localparam int WIDTH  = 16;
   localparam int AWIDTH = 5;
   localparam int NPAIRS = 8;
   localparam int KW     = 3;
   localparam int DEPTH  = 1 << AWIDTH;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic              strobe_in;
   logic [WIDTH-1:0]  data_in;
   logic              write;
   logic [AWIDTH-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic [AWIDTH-1:0] rd_addr1;
   logic [AWIDTH-1:0] rd_addr2;
   logic [AWIDTH-1:0] center_addr;
   logic [KW-1:0]     coeff_idx;
   logic              rd_valid;
   logic              rd_first;
   logic              rd_last;
   logic              sum_valid;
   logic              sum_first;
   logic              sum_last;
   logic              busy;
   logic              overrun;

   hb_dec_tap_sequencer #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .NPAIRS(NPAIRS)) dut (
      .clock(clock), .reset(reset), .enable(enable), .strobe_in(strobe_in),
      .data_in(data_in), .write(write), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .center_addr(center_addr),
      .coeff_idx(coeff_idx), .rd_valid(rd_valid), .rd_first(rd_first),
      .rd_last(rd_last), .sum_valid(sum_valid), .sum_first(sum_first),
      .sum_last(sum_last), .busy(busy), .overrun(overrun)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int bursts   = 0;

   // Reference model: bursts are scheduled by the edge index at which they trigger.
   int n_edge, m_ptr, m_start, m_newest, m_phase, m_active, m_over;
   int exp_write, exp_waddr, exp_wdata, exp_rv, exp_k;
   int exp_sv, exp_sf, exp_sl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wrap(input int a);
      return ((a % DEPTH) + DEPTH) % DEPTH;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_phase = 0; m_active = 0; m_over = 0; m_start = 0; m_newest = 0;
      exp_write = 0; exp_waddr = 0; exp_wdata = 0; exp_rv = 0; exp_k = 0;
      exp_sv = 0; exp_sf = 0; exp_sl = 0;
   endtask

   task automatic model_update(input int en, input int stb, input int data);
      int acc, busy_pre;
      n_edge++;
      acc      = en & stb;
      busy_pre = m_active;
      exp_sv   = exp_rv;
      exp_sf   = (exp_rv != 0) && (exp_k == 0);
      exp_sl   = (exp_rv != 0) && (exp_k == NPAIRS - 1);
      exp_write = acc;
      if (acc != 0) begin
         exp_waddr = m_ptr;
         exp_wdata = data;
      end
      if (en == 0) begin
         m_active = 0;
         m_phase  = 0;
      end else begin
         if (m_active != 0 && n_edge == m_start + NPAIRS + 1) m_active = 0;
         if (acc != 0 && m_phase != 0) begin
            if (busy_pre != 0) m_over = 1;
            else begin
               m_active = 1;
               m_start  = n_edge;
               m_newest = m_ptr;
            end
         end
         if (acc != 0) m_phase = 1 - m_phase;
      end
      if (acc != 0) m_ptr = wrap(m_ptr + 1);
      exp_rv = (m_active != 0) && (n_edge > m_start);
      exp_k  = n_edge - m_start - 1;
   endtask

   task automatic compare_all();
      check("write", 32'(write), 32'(exp_write));
      if (exp_write != 0) begin
         check("wr_addr", 32'(wr_addr), 32'(exp_waddr));
         check("wr_data", 32'(wr_data), 32'(exp_wdata));
      end
      check("rd_valid", 32'(rd_valid), 32'(exp_rv));
      check("rd_first", 32'(rd_first), 32'((exp_rv != 0) && exp_k == 0));
      check("rd_last", 32'(rd_last), 32'((exp_rv != 0) && exp_k == NPAIRS - 1));
      if (exp_rv != 0) begin
         check("rd_addr1", 32'(rd_addr1), 32'(wrap(m_newest - 2 * exp_k)));
         check("rd_addr2", 32'(rd_addr2), 32'(wrap(m_newest - (4 * NPAIRS - 2) + 2 * exp_k)));
         check("center_addr", 32'(center_addr), 32'(wrap(m_newest - (2 * NPAIRS - 1))));
         check("coeff_idx", 32'(coeff_idx), 32'(exp_k));
      end
      check("sum_valid", 32'(sum_valid), 32'(exp_sv));
      check("sum_first", 32'(sum_first), 32'(exp_sf));
      check("sum_last", 32'(sum_last), 32'(exp_sl));
      check("busy", 32'(busy), 32'(m_active));
      check("overrun", 32'(overrun), 32'(m_over));
   endtask

   task automatic check_all_zero();
      check("rst_write", 32'(write), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_rd_addr1", 32'(rd_addr1), 0);
      check("rst_rd_addr2", 32'(rd_addr2), 0);
      check("rst_center", 32'(center_addr), 0);
      check("rst_coeff", 32'(coeff_idx), 0);
      check("rst_rd_flags", 32'({rd_valid, rd_first, rd_last}), 0);
      check("rst_sum_flags", 32'({sum_valid, sum_first, sum_last}), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
   endtask

   task automatic step(input int en, input int stb, input int data);
      enable    = (en != 0);
      strobe_in = (stb != 0);
      data_in   = WIDTH'(data);
      @(posedge clock);
      model_update(en, stb, data);
      #1;
      compare_all();
      if (rd_valid && rd_first) bursts++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; strobe_in = 1'b0; data_in = '0;
      n_edge = 0;
      model_reset();
      #1;
      check_all_zero();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Two samples -> one burst from newest=1.
      step(1, 1, 16'h0101);
      step(1, 1, 16'h0202);
      step(1, 0, 0);
      check("first_addr1", 32'(rd_addr1), 1);
      check("first_addr2", 32'(rd_addr2), 3);
      check("first_center", 32'(center_addr), 18);
      idle(7);
      check("last_addr1", 32'(rd_addr1), 19);
      check("last_addr2", 32'(rd_addr2), 17);
      check("last_flag", 32'(rd_last), 1);
      idle(4);

      // 64 well-spaced samples: pointer wraps, 32 bursts, no overrun.
      bursts = 0;
      for (int s = 0; s < 64; s++) begin
         step(1, 1, int'($urandom_range(0, 65535)));
         idle(4);
      end
      idle(12);
      check("spaced_bursts", 32'(bursts), 32);
      check("spaced_overrun", 32'(overrun), 0);

      // Back-to-back samples: later triggers collide with the running burst.
      bursts = 0;
      for (int s = 0; s < 10; s++) step(1, 1, int'($urandom_range(0, 65535)));
      idle(12);
      check("b2b_bursts", 32'(bursts), 1);
      check("b2b_overrun", 32'(overrun), 1);

      // Asynchronous reset in the middle of a burst.
      step(1, 1, 16'h1111);
      step(1, 1, 16'h2222);
      idle(3);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all_zero();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      step(1, 1, 16'h3333);
      check("post_rst_addr", 32'(wr_addr), 0);
      idle(2);

      // Enable drop at k=3, after an odd accept so the phase clear matters.
      step(1, 1, 16'h4444);
      idle(4);
      check("pre_drop_k", 32'(coeff_idx), 3);
      step(0, 0, 0);
      check("drop_rv", 32'(rd_valid), 0);
      check("drop_sv", 32'(sum_valid), 1);
      step(0, 0, 0);
      check("drop_sv2", 32'(sum_valid), 0);
      step(1, 1, 16'h5555);
      step(0, 0, 0);
      bursts = 0;
      step(1, 1, 16'h6666);
      step(1, 1, 16'h7777);
      idle(12);
      check("restart_bursts", 32'(bursts), 1);

      // Random traffic.
      for (int c = 0; c < 600; c++)
         step(($urandom_range(0, 19) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 65535)));
      idle(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
